// File: rtl/snake_body_ctrl_if.sv
// Body-FIFO and frame-buffer painter signals of the snake body controller.
// master = controller side, slave = FIFO/painter side.
interface snake_body_ctrl_if #(
   parameter int COORD_W = 8
);
   logic                   fifo_write;
   logic [2*COORD_W-1:0]   fifo_wdata;
   logic                   fifo_read;
   logic [2*COORD_W-1:0]   fifo_rdata;
   logic                   fifo_empty;
   logic                   draw_valid;
   logic                   draw_ready;
   logic [COORD_W-1:0]     draw_x;
   logic [COORD_W-1:0]     draw_y;
   logic                   draw_color;

   modport master (
      output fifo_write, fifo_wdata, fifo_read, draw_valid, draw_x, draw_y, draw_color,
      input  fifo_rdata, fifo_empty, draw_ready
   );

   modport slave (
      input  fifo_write, fifo_wdata, fifo_read, draw_valid, draw_x, draw_y, draw_color,
      output fifo_rdata, fifo_empty, draw_ready
   );
endinterface

// File: rtl/snake_body_ctrl.sv
// Snake body controller: seeds the body FIFO, then per tick pushes the new head,
// erases/pops the tail unless growing, and freezes on a wall hit.
module snake_body_ctrl #(
   parameter int COORD_W  = 8,
   parameter int GRID_W   = 32,
   parameter int GRID_H   = 24,
   parameter int INIT_LEN = 3,
   parameter int START_X  = 10,
   parameter int START_Y  = 12,
   parameter int MAX_LEN  = 63
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 tick,
   input  logic [1:0]           dir,
   input  logic                 grow,
   snake_body_ctrl_if.master    bus,
   output logic [COORD_W-1:0]   head_x,
   output logic [COORD_W-1:0]   head_y,
   output logic [6:0]           length,
   output logic                 wall_hit,
   output logic                 busy
);

   localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
   localparam logic [COORD_W-1:0] INIT_X = COORD_W'(START_X - INIT_LEN + 1);
   localparam logic [COORD_W-1:0] STX    = COORD_W'(START_X);
   localparam logic [COORD_W-1:0] STY    = COORD_W'(START_Y);
   localparam logic [COORD_W-1:0] LAST_X = COORD_W'(GRID_W - 1);
   localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(GRID_H - 1);
   localparam logic [6:0]         MAXL   = 7'(MAX_LEN);

   typedef enum logic [2:0] {
      S_INIT, S_INIT_DRAW, S_IDLE, S_CALC, S_HEAD, S_HEAD_DRAW, S_TAIL, S_DEAD
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           cur_dir;
   logic                 grow_pend;
   logic [COORD_W-1:0]   nxt_x, nxt_y, tail_x, tail_y;
   logic [COORD_W-1:0]   calc_x, calc_y;
   logic                 tail_empty;
   logic                 wall;
   logic                 init_last, grow_ok, hs;
   logic                 wr, rd, dv, dc;
   logic [COORD_W-1:0]   dx, dy;
   logic [2*COORD_W-1:0] wd;

   assign init_last = (head_x == STX);
   assign grow_ok   = grow_pend && (length < MAXL);
   assign hs        = dv && bus.draw_ready;
   assign busy      = (state_q != S_IDLE) && (state_q != S_DEAD);

   always_comb begin
      calc_x = head_x;
      calc_y = head_y;
      wall   = 1'b0;
      case (cur_dir)
         2'b00:   begin wall = (head_y == '0);     calc_y = head_y - ONE; end
         2'b01:   begin wall = (head_x == LAST_X); calc_x = head_x + ONE; end
         2'b10:   begin wall = (head_y == LAST_Y); calc_y = head_y + ONE; end
         default: begin wall = (head_x == '0);     calc_x = head_x - ONE; end
      endcase
   end

   // Outputs are held quiet while rstn is low, even though the state sits in INIT.
   always_comb begin
      state_d = state_q;
      wr = 1'b0;
      rd = 1'b0;
      dv = 1'b0;
      dc = 1'b0;
      dx = '0;
      dy = '0;
      wd = '0;
      if (rstn) begin
         case (state_q)
            S_INIT, S_INIT_DRAW: begin
               wr = (state_q == S_INIT);
               wd = {head_x, head_y};
               dv = 1'b1;
               dc = 1'b1;
               dx = head_x;
               dy = head_y;
               if (bus.draw_ready) state_d = init_last ? S_IDLE : S_INIT;
               else                state_d = S_INIT_DRAW;
            end
            S_IDLE: if (tick) state_d = S_CALC;
            S_CALC: state_d = wall ? S_DEAD : S_HEAD;
            S_HEAD, S_HEAD_DRAW: begin
               wr = (state_q == S_HEAD);
               wd = {nxt_x, nxt_y};
               dv = 1'b1;
               dc = 1'b1;
               dx = nxt_x;
               dy = nxt_y;
               if (bus.draw_ready) state_d = grow_ok ? S_IDLE : S_TAIL;
               else                state_d = S_HEAD_DRAW;
            end
            S_TAIL: begin
               if (tail_empty) begin
                  state_d = S_IDLE;
               end else begin
                  dv = 1'b1;
                  dx = tail_x;
                  dy = tail_y;
                  if (bus.draw_ready) begin
                     rd      = 1'b1;
                     state_d = S_IDLE;
                  end
               end
            end
            default: state_d = S_DEAD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= S_INIT;
         head_x     <= INIT_X;
         head_y     <= STY;
         length     <= '0;
         wall_hit   <= 1'b0;
         cur_dir    <= 2'b01;
         grow_pend  <= 1'b0;
         nxt_x      <= '0;
         nxt_y      <= '0;
         tail_x     <= '0;
         tail_y     <= '0;
         tail_empty <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grow && state_q != S_DEAD) grow_pend <= 1'b1;
         case (state_q)
            S_INIT, S_INIT_DRAW: begin
               if (state_q == S_INIT) length <= length + 7'd1;
               if (hs && !init_last)  head_x <= head_x + ONE;
            end
            S_IDLE: if (tick && ((dir ^ cur_dir) != 2'b10)) cur_dir <= dir;
            S_CALC: begin
               nxt_x      <= calc_x;
               nxt_y      <= calc_y;
               tail_x     <= bus.fifo_rdata[2*COORD_W-1:COORD_W];
               tail_y     <= bus.fifo_rdata[COORD_W-1:0];
               tail_empty <= bus.fifo_empty;
               if (wall) wall_hit <= 1'b1;
            end
            S_HEAD, S_HEAD_DRAW: begin
               if (state_q == S_HEAD) begin
                  head_x <= nxt_x;
                  head_y <= nxt_y;
               end
               // A fresh grow pulse on the consuming cycle survives for the next step.
               if (hs) begin
                  grow_pend <= grow;
                  if (grow_ok) length <= length + 7'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.fifo_write = wr;
   assign bus.fifo_wdata = wd;
   assign bus.fifo_read  = rd;
   assign bus.draw_valid = dv;
   assign bus.draw_color = dc;
   assign bus.draw_x     = dx;
   assign bus.draw_y     = dy;

endmodule
